// File: rtl/unbin_pkg.sv
// rtl/unbin_pkg.sv - shared constants and helpers for the mask unbinning block
package unbin_pkg;

    // Replication factor per axis and its log2; only 4x4 is supported.
    localparam int KERNEL_SIZE = 4;
    localparam int LOG2_KERNEL = 2;

    // Read latency of the line-buffer path (BRAM read register + output register).
    localparam int RD_LAT = 2;

    // Width of a coarse (binned) coordinate given the full-res coordinate width.
    function automatic int coarse_width(input int width);
        return width - LOG2_KERNEL;
    endfunction

endpackage

// File: rtl/unbinning_2_if.sv
// rtl/unbinning_2_if.sv - binned 1-bit mask write stream (coarse coordinates)
//
// Signals:
//   pixel_data_in  binned mask pixel
//   hcount_in      binned column, CW_H bits
//   vcount_in      binned row, CW_V bits
//   data_valid_in  binned pixel valid
// Modports: master drives the stream, slave receives it.
interface unbinning_2_if #(
    parameter int CW_H = 9,
    parameter int CW_V = 8
);
    logic            pixel_data_in;
    logic [CW_H-1:0] hcount_in;
    logic [CW_V-1:0] vcount_in;
    logic            data_valid_in;

    modport master (
        output pixel_data_in,
        output hcount_in,
        output vcount_in,
        output data_valid_in
    );

    modport slave (
        input pixel_data_in,
        input hcount_in,
        input vcount_in,
        input data_valid_in
    );
endinterface

// File: rtl/xilinx_true_dual_port_read_first_1_clock_ram.sv
// rtl/xilinx_true_dual_port_read_first_1_clock_ram.sv - single-clock dual-port read-first RAM
//
// Ports:
//   clka                  common clock for both ports
//   addra/dina/wea        port A write side
//   addrb/enb             port B read address / read enable
//   rstb/regceb           port B output register reset / clock enable
//   doutb                 port B read data
// RAM_PERFORMANCE "HIGH_PERFORMANCE" adds an output register (2-cycle read),
// "LOW_LATENCY" returns the array read register directly (1-cycle read).
module xilinx_true_dual_port_read_first_1_clock_ram #(
    parameter int RAM_WIDTH       = 1,
    parameter int RAM_DEPTH       = 320,
    parameter     RAM_PERFORMANCE = "HIGH_PERFORMANCE",
    localparam int AW             = $clog2(RAM_DEPTH)
) (
    input  logic                 clka,
    input  logic [AW-1:0]        addra,
    input  logic [RAM_WIDTH-1:0] dina,
    input  logic                 wea,
    input  logic [AW-1:0]        addrb,
    input  logic                 enb,
    input  logic                 rstb,
    input  logic                 regceb,
    output logic [RAM_WIDTH-1:0] doutb
);
    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] ram_data_b;

    always_ff @(posedge clka) begin
        if (wea) begin
            mem[addra] <= dina;
        end
    end

    // Non-blocking read alongside the write gives read-first collision behaviour.
    always_ff @(posedge clka) begin
        if (enb) begin
            ram_data_b <= mem[addrb];
        end
    end

    if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_low_latency
        assign doutb = ram_data_b;
    end else begin : g_high_performance
        logic [RAM_WIDTH-1:0] doutb_reg;
        always_ff @(posedge clka) begin
            if (rstb) begin
                doutb_reg <= '0;
            end else if (regceb) begin
                doutb_reg <= ram_data_b;
            end
        end
        assign doutb = doutb_reg;
    end
endmodule

// File: rtl/unbinning_2.sv
// rtl/unbinning_2.sv - re-expand a 4x4-binned 1-bit mask to full resolution
//
// Ports:
//   clk_in, rst_in        clock, synchronous active-high reset
//   wr (slave)            binned mask write stream, coarse coordinates
//   hcount_rd_in          full-res read column
//   vcount_rd_in          full-res read line
//   rd_valid_in           read request valid (active video)
//   pixel_data_out        upscaled mask pixel, 2 cycles after the read request
//   hcount_out/vcount_out read coordinates aligned with pixel_data_out
//   data_valid_out        rd_valid_in aligned with pixel_data_out
// Optional: define UNBIN_GRID_EN to overlay the 4x4 block grid on valid pixels.
module unbinning_2 #(
    parameter int  HRES        = 1280,
    parameter int  VRES        = 720,
    parameter int  KERNEL_SIZE = unbin_pkg::KERNEL_SIZE,
    localparam int HWIDTH      = $clog2(HRES),
    localparam int VWIDTH      = $clog2(VRES),
    localparam int CW_H        = unbin_pkg::coarse_width(HWIDTH),
    localparam int CW_V        = unbin_pkg::coarse_width(VWIDTH)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    unbinning_2_if.slave      wr,
    input  logic [HWIDTH-1:0] hcount_rd_in,
    input  logic [VWIDTH-1:0] vcount_rd_in,
    input  logic              rd_valid_in,
    output logic              pixel_data_out,
    output logic [HWIDTH-1:0] hcount_out,
    output logic [VWIDTH-1:0] vcount_out,
    output logic              data_valid_out
);
    localparam int RD_LAT = unbin_pkg::RD_LAT;
    localparam int DEPTH  = HRES / KERNEL_SIZE;

    if (KERNEL_SIZE != unbin_pkg::KERNEL_SIZE) begin : g_bad_kernel
        $error("unbinning_2: only KERNEL_SIZE=4 is supported");
    end

    // Only the row LSB selects the bank; upper row bits carry no state.
    wire unused_vcount_hi = ^wr.vcount_in[CW_V-1:1];

    // Registered write stage feeding the BRAM port A.
    logic            wr_en_q;
    logic            wr_bank_q;
    logic            wr_data_q;
    logic [CW_H-1:0] wr_addr_q;
    logic [1:0]      bank_ok;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_en_q   <= 1'b0;
            wr_bank_q <= 1'b0;
            wr_data_q <= 1'b0;
            wr_addr_q <= '0;
            bank_ok   <= 2'b00;
        end else begin
            wr_en_q   <= wr.data_valid_in;
            wr_bank_q <= wr.vcount_in[0];
            wr_data_q <= wr.pixel_data_in;
            wr_addr_q <= wr.hcount_in;
            // A bank becomes readable only once a whole coarse row has landed in it.
            if (wr_en_q) begin
                if (wr_addr_q == '0) begin
                    bank_ok[wr_bank_q] <= 1'b0;
                end
                if (wr_addr_q == CW_H'(DEPTH - 1)) begin
                    bank_ok[wr_bank_q] <= 1'b1;
                end
            end
        end
    end

    // Lines 4k..4k+3 show coarse row k-1, which lives in bank (k-1)&1 = ~k&1.
    logic            rd_bank;
    logic [CW_H-1:0] rd_addr;
    logic [1:0]      bank_dout;

    assign rd_bank = ~vcount_rd_in[2];
    assign rd_addr = hcount_rd_in[HWIDTH-1:2];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        xilinx_true_dual_port_read_first_1_clock_ram #(
            .RAM_WIDTH      (1),
            .RAM_DEPTH      (DEPTH),
            .RAM_PERFORMANCE("HIGH_PERFORMANCE")
        ) u_ram (
            .clka  (clk_in),
            .addra (wr_addr_q),
            .dina  (wr_data_q),
            .wea   (wr_en_q && (wr_bank_q == 1'(b))),
            .addrb (rd_addr),
            .enb   (1'b1),
            .rstb  (rst_in),
            .regceb(1'b1),
            .doutb (bank_dout[b])
        );
    end

    // Alignment pipe matching the BRAM read latency; advances every cycle.
    logic [RD_LAT-1:0] vld_pipe;
    logic [RD_LAT-1:0] ok_pipe;
    logic [RD_LAT-1:0] bank_pipe;
    logic [HWIDTH-1:0] hc_pipe [RD_LAT];
    logic [VWIDTH-1:0] vc_pipe [RD_LAT];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            vld_pipe  <= '0;
            ok_pipe   <= '0;
            bank_pipe <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                hc_pipe[i] <= '0;
                vc_pipe[i] <= '0;
            end
        end else begin
            vld_pipe  <= {vld_pipe[RD_LAT-2:0], rd_valid_in};
            ok_pipe   <= {ok_pipe[RD_LAT-2:0], bank_ok[rd_bank]};
            bank_pipe <= {bank_pipe[RD_LAT-2:0], rd_bank};
            hc_pipe[0] <= hcount_rd_in;
            vc_pipe[0] <= vcount_rd_in;
            for (int i = 1; i < RD_LAT; i++) begin
                hc_pipe[i] <= hc_pipe[i-1];
                vc_pipe[i] <= vc_pipe[i-1];
            end
        end
    end

    logic bin_pix;
    assign bin_pix = bank_dout[bank_pipe[RD_LAT-1]] & ok_pipe[RD_LAT-1];

    assign data_valid_out = vld_pipe[RD_LAT-1];
    assign hcount_out     = hc_pipe[RD_LAT-1];
    assign vcount_out     = vc_pipe[RD_LAT-1];

`ifdef UNBIN_GRID_EN
    logic grid_pix;
    assign grid_pix       = (hcount_out[1:0] == 2'b00) || (vcount_out[1:0] == 2'b00);
    assign pixel_data_out = data_valid_out & (bin_pix | grid_pix);
`else
    assign pixel_data_out = data_valid_out & bin_pix;
`endif

endmodule

// File: tb/tb_unbinning_2.sv
// tb/tb_unbinning_2.sv - randomized self-checking bench for unbinning_2
module tb_unbinning_2;
    localparam int HRES  = 64;
    localparam int VRES  = 48;
    localparam int HW    = 6;
    localparam int VW    = 6;
    localparam int CH    = 4;
    localparam int CV    = 4;
    localparam int DEPTH = HRES / 4;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic [HW-1:0] hcount_rd_in;
    logic [VW-1:0] vcount_rd_in;
    logic          rd_valid_in;
    logic          pixel_data_out;
    logic [HW-1:0] hcount_out;
    logic [VW-1:0] vcount_out;
    logic          data_valid_out;

    always #5 clk_in = ~clk_in;

    unbinning_2_if #(.CW_H(CH), .CW_V(CV)) wr_if ();

    unbinning_2 #(
        .HRES       (HRES),
        .VRES       (VRES),
        .KERNEL_SIZE(4)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .wr            (wr_if),
        .hcount_rd_in  (hcount_rd_in),
        .vcount_rd_in  (vcount_rd_in),
        .rd_valid_in   (rd_valid_in),
        .pixel_data_out(pixel_data_out),
        .hcount_out    (hcount_out),
        .vcount_out    (vcount_out),
        .data_valid_out(data_valid_out)
    );

    // Reference: stored coarse rows per bank and whether each bank holds a complete row.
    bit mem_m [2][DEPTH];
    bit ok_m  [2];

    typedef struct {
        bit rst;
        bit vld;
        bit pix;
        int h;
        int v;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Full-res line v shows coarse row v/4-1, which was written into bank (row mod 2).
    function automatic bit model_pix(input int h, input int v, input bit vld);
        int bank;
        bit p;
        bank = ((v / 4) + 1) % 2;
        p = vld && ok_m[bank] && mem_m[bank][h / 4];
`ifdef UNBIN_GRID_EN
        if (vld && ((h % 4) == 0 || (v % 4) == 0)) p = 1'b1;
`endif
        return p;
    endfunction

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    // One cycle of stimulus; the expected output for this request is queued.
    task automatic step(input bit rst, input bit wv, input int wh, input int wrow, input bit wp,
                        input bit rv, input int rh, input int rline);
        exp_t e;
        @(posedge clk_in);
        #1;
        rst_in              = rst;
        wr_if.data_valid_in = wv;
        wr_if.hcount_in     = CH'(wh);
        wr_if.vcount_in     = CV'(wrow);
        wr_if.pixel_data_in = wp;
        rd_valid_in         = rv;
        hcount_rd_in        = HW'(rh);
        vcount_rd_in        = VW'(rline);
        if (rst) begin
            ok_m[0] = 1'b0;
            ok_m[1] = 1'b0;
        end else if (wv) begin
            mem_m[wrow % 2][wh] = wp;
            if (wh == 0)         ok_m[wrow % 2] = 1'b0;
            if (wh == DEPTH - 1) ok_m[wrow % 2] = 1'b1;
        end
        e.rst = rst;
        e.vld = rv;
        e.pix = model_pix(rh, rline, rv);
        e.h   = rh;
        e.v   = rline;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic write_span(input int row, input int lo, input int hi, input bit [15:0] pat);
        for (int h = lo; h <= hi; h++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            step(1'b0, 1'b1, h, row, pat[h], 1'b0, 0, 0);
        end
        idle(3);
    endtask

    task automatic read_lines(input int a, input int b);
        for (int v = a; v <= b; v++)
            for (int h = 0; h < HRES; h++)
                step(1'b0, 1'b0, 0, 0, 1'b0, ($urandom_range(0, 3) != 0), h, v);
        idle(2);
    endtask

    // Compare process: outputs after edge k reflect the request sampled at edge k-1,
    // unless reset was sampled at edge k-1 or k.
    exp_t ca, cb;
    bit   zero;
    always @(negedge clk_in) begin
        if (q.size() >= 3) begin
            ca   = q[0];
            cb   = q[1];
            zero = ca.rst || cb.rst;
            chk("data_valid_out", int'(data_valid_out), zero ? 0 : int'(ca.vld));
            chk("pixel_data_out", int'(pixel_data_out), zero ? 0 : int'(ca.pix));
            chk("hcount_out",     int'(hcount_out),     zero ? 0 : ca.h);
            chk("vcount_out",     int'(vcount_out),     zero ? 0 : ca.v);
            void'(q.pop_front());
        end
    end

    initial begin
        rst_in              = 1'b1;
        wr_if.data_valid_in = 1'b0;
        wr_if.hcount_in     = '0;
        wr_if.vcount_in     = '0;
        wr_if.pixel_data_in = 1'b0;
        rd_valid_in         = 1'b0;
        hcount_rd_in        = '0;
        vcount_rd_in        = '0;

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 0, 0);
        idle(2);

        // Reads before any write: everything masked.
        read_lines(0, 7);

        // Single set bin at coarse column 5 of row 0.
        write_span(0, 0, DEPTH - 1, 16'h0020);
`ifndef UNBIN_GRID_EN
        chk("model_bin5_first",  int'(model_pix(20, 4, 1'b1)), 1);
        chk("model_bin5_last",   int'(model_pix(23, 7, 1'b1)), 1);
        chk("model_bin5_right",  int'(model_pix(24, 4, 1'b1)), 0);
        chk("model_bin5_left",   int'(model_pix(19, 5, 1'b1)), 0);
`endif
        read_lines(4, 7);

        // Row 0 all ones, row 1 all zeros: bank swap between lines 7 and 8.
        write_span(0, 0, DEPTH - 1, 16'hFFFF);
        write_span(1, 0, DEPTH - 1, 16'h0000);
`ifndef UNBIN_GRID_EN
        chk("model_row0_ones",  int'(model_pix(2, 5, 1'b1)), 1);
        chk("model_row1_zeros", int'(model_pix(63, 11, 1'b1)), 0);
`endif
        read_lines(4, 11);

        // Partial row 2 leaves bank 0 masked; completing it unmasks.
        write_span(2, 0, 10, 16'hA5A5);
        chk("model_partial_masked", int'(model_pix(21, 13, 1'b1)), 0);
        read_lines(12, 15);
        write_span(2, 11, DEPTH - 1, 16'hA5A5);
        chk("model_partial_done", int'(model_pix(21, 13, 1'b1)), 1);
        read_lines(12, 15);

        // Random rows, then the last row read back at the frame wrap (lines 0..3).
        for (int r = 3; r <= 8; r++) begin
            write_span(r, 0, DEPTH - 1, 16'($urandom));
            read_lines(4 * r + 4, 4 * r + 7);
        end
        write_span(VRES / 4 - 1, 0, DEPTH - 1, 16'($urandom));
        read_lines(0, 3);

        // Reset in the middle of a continuous read sweep.
        write_span(0, 0, DEPTH - 1, 16'hFFFF);
        for (int v = 4; v <= 5; v++)
            for (int h = 0; h < HRES; h++)
                step((v == 4 && h == 30), 1'b0, 0, 0, 1'b0, 1'b1, h, v);
        idle(2);
`ifndef UNBIN_GRID_EN
        chk("model_after_reset", int'(model_pix(5, 4, 1'b1)), 0);
`else
        chk("model_grid_line4",   int'(model_pix(7, 4, 1'b1)), 1);
        chk("model_grid_line5",   int'(model_pix(7, 5, 1'b1)), 0);
        chk("model_grid_col0",    int'(model_pix(8, 5, 1'b1)), 1);
`endif
        read_lines(4, 7);
        write_span(0, 0, DEPTH - 1, 16'hFFFF);
        read_lines(4, 7);

        idle(4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
